rv32i_instr_encoder: RTL and testbench

//  Encodes one fe_pkg mnemonic plus operand fields into a 32-bit RV32I instruction word.

---
 rtl/fe_pkg.sv | 60 ++++++
 rtl/rv32i_instr_encoder_if.sv | 26 ++
 rtl/rv32i_instr_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - RV32I mnemonic and opcode enumerations shared by the front end
package fe_pkg;

    typedef enum logic [5:0] {
        NULL   = 6'd0,
        LUI    = 6'd1,
        AUIPC  = 6'd2,
        JAL    = 6'd3,
        JALR   = 6'd4,
        BEQ    = 6'd5,
        BNE    = 6'd6,
        BLT    = 6'd7,
        BGE    = 6'd8,
        BLTU   = 6'd9,
        BGEU   = 6'd10,
        LB     = 6'd11,
        LH     = 6'd12,
        LW     = 6'd13,
        LBU    = 6'd14,
        LHU    = 6'd15,
        SB     = 6'd16,
        SH     = 6'd17,
        SW     = 6'd18,
        ADDI   = 6'd19,
        SLTI   = 6'd20,
        SLTIU  = 6'd21,
        XORI   = 6'd22,
        ORI    = 6'd23,
        ANDI   = 6'd24,
        SLLI   = 6'd25,
        SRLI   = 6'd26,
        SRAI   = 6'd27,
        ADD    = 6'd28,
        SUB    = 6'd29,
        SLL    = 6'd30,
        SLT    = 6'd31,
        SLTU   = 6'd32,
        XOR    = 6'd33,
        SRL    = 6'd34,
        SRA    = 6'd35,
        OR     = 6'd36,
        AND    = 6'd37,
        ECALL  = 6'd38,
        EBREAK = 6'd39
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } RV32I_OPCODE_t;

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// rtl/rv32i_instr_encoder_if.sv - request and encoded-word stream signals of the encoder
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 32
) ();
    logic                                in_valid;
    logic                                in_ready;
    fe_pkg::RV32I_INSTRUCTION_MNEMONIC_t in_mnem;
    logic [4:0]                          in_rd;
    logic [4:0]                          in_rs1;
    logic [4:0]                          in_rs2;
    logic [31:0]                         in_imm;
    logic                                out_valid;
    logic                                out_ready;
    logic [31:0]                         out_data;
    logic [ADDR_W-1:0]                   out_addr;

    modport master (
        output in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    modport slave (
        input  in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - mnemonic + operands to RV32I word, streamed with auto-incrementing address
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rv32i_instr_encoder_if.slave        bus,
    input  logic                        addr_clr,
    output logic                        err,
    output logic [7:0]                  err_cnt
);
    import fe_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_EMIT} state_t;
    typedef enum logic [3:0] {F_R, F_I, F_SH, F_S, F_B, F_J, F_U, F_SYS, F_BAD} fmt_t;

    state_t                      state, state_nxt;
    RV32I_INSTRUCTION_MNEMONIC_t mnem_q;
    logic [4:0]                  rd_q, rs1_q, rs2_q;
    logic [31:0]                 imm_q;
    logic signed [31:0]          imm_s;
    logic [31:0]                 data_q;
    logic [ADDR_W-1:0]           addr_q, counter;
    fmt_t                        fmt;
    RV32I_OPCODE_t               opc;
    logic [2:0]                  f3;
    logic [6:0]                  f7;
    logic [31:0]                 word;
    logic                        legal;
    logic                        in_ready_c, out_valid_c, err_c;

    assign imm_s         = imm_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign err           = err_c;

    // Mnemonic to instruction format, opcode and function fields
    always_comb begin
        fmt = F_BAD;
        opc = OPC_OP;
        f3  = 3'd0;
        f7  = 7'd0;
        case (mnem_q)
            LUI:    begin fmt = F_U;  opc = OPC_LUI;    end
            AUIPC:  begin fmt = F_U;  opc = OPC_AUIPC;  end
            JAL:    begin fmt = F_J;  opc = OPC_JAL;    end
            JALR:   begin fmt = F_I;  opc = OPC_JALR;   end
            BEQ:    begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd0; end
            BNE:    begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd1; end
            BLT:    begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd4; end
            BGE:    begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd5; end
            BLTU:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd6; end
            BGEU:   begin fmt = F_B;  opc = OPC_BRANCH; f3 = 3'd7; end
            LB:     begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd0; end
            LH:     begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd1; end
            LW:     begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd2; end
            LBU:    begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd4; end
            LHU:    begin fmt = F_I;  opc = OPC_LOAD;   f3 = 3'd5; end
            SB:     begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd0; end
            SH:     begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd1; end
            SW:     begin fmt = F_S;  opc = OPC_STORE;  f3 = 3'd2; end
            ADDI:   begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd0; end
            SLTI:   begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd2; end
            SLTIU:  begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd3; end
            XORI:   begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd4; end
            ORI:    begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd6; end
            ANDI:   begin fmt = F_I;  opc = OPC_OP_IMM; f3 = 3'd7; end
            SLLI:   begin fmt = F_SH; opc = OPC_OP_IMM; f3 = 3'd1; end
            SRLI:   begin fmt = F_SH; opc = OPC_OP_IMM; f3 = 3'd5; end
            SRAI:   begin fmt = F_SH; opc = OPC_OP_IMM; f3 = 3'd5; f7 = 7'b0100000; end
            ADD:    begin fmt = F_R;  f3 = 3'd0; end
            SUB:    begin fmt = F_R;  f3 = 3'd0; f7 = 7'b0100000; end
            SLL:    begin fmt = F_R;  f3 = 3'd1; end
            SLT:    begin fmt = F_R;  f3 = 3'd2; end
            SLTU:   begin fmt = F_R;  f3 = 3'd3; end
            XOR:    begin fmt = F_R;  f3 = 3'd4; end
            SRL:    begin fmt = F_R;  f3 = 3'd5; end
            SRA:    begin fmt = F_R;  f3 = 3'd5; f7 = 7'b0100000; end
            OR:     begin fmt = F_R;  f3 = 3'd6; end
            AND:    begin fmt = F_R;  f3 = 3'd7; end
            ECALL:  begin fmt = F_SYS; opc = OPC_SYSTEM; end
            EBREAK: begin fmt = F_SYS; opc = OPC_SYSTEM; end
            default: fmt = F_BAD;
        endcase
    end

    // Field packing per format; fields a format does not use are left as zero
    always_comb begin
        word  = 32'd0;
        legal = 1'b0;
        case (fmt)
            F_R: begin
                word  = {f7, rs2_q, rs1_q, f3, rd_q, opc};
                legal = 1'b1;
            end
            F_I: begin
                word  = {imm_q[11:0], rs1_q, f3, rd_q, opc};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            F_SH: begin
                word  = {f7, imm_q[4:0], rs1_q, f3, rd_q, opc};
                legal = (imm_q < 32'd32);
            end
            F_S: begin
                word  = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc};
                legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            F_B: begin
                word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc};
                legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_q[0];
            end
            F_J: begin
                word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
                legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_q[0];
            end
            F_U: begin
                word  = {imm_q[31:12], rd_q, opc};
                legal = (imm_q[11:0] == 12'd0);
            end
            F_SYS: begin
                word  = (mnem_q == EBREAK) ? 32'h0010_0073 : 32'h0000_0073;
                legal = 1'b1;
            end
            default: begin
                word  = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        err_c       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = S_ENCODE;
            end
            S_ENCODE: begin
                err_c     = !legal;
                state_nxt = legal ? S_EMIT : S_IDLE;
            end
            S_EMIT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Request capture on accept so later input changes cannot disturb the encode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mnem_q <= NULL;
            rd_q   <= 5'd0;
            rs1_q  <= 5'd0;
            rs2_q  <= 5'd0;
            imm_q  <= 32'd0;
        end else if (state == S_IDLE && bus.in_valid) begin
            mnem_q <= bus.in_mnem;
            rd_q   <= bus.in_rd;
            rs1_q  <= bus.in_rs1;
            rs2_q  <= bus.in_rs2;
            imm_q  <= bus.in_imm;
        end
    end

    // Output word and its address, frozen from ENCODE until the EMIT handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 32'd0;
            addr_q <= BASE_ADDR;
        end else if (state == S_ENCODE && legal) begin
            data_q <= word;
            addr_q <= counter;
        end
    end

    // Address counter; a clear takes priority over the post-handshake increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              counter <= BASE_ADDR;
        else if (addr_clr)                       counter <= BASE_ADDR;
        else if (state == S_EMIT && bus.out_ready) counter <= counter + ADDR_W'(4);
    end

    // Saturating count of rejected requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt <= 8'd0;
        else if (err_c && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - randomized self-checking bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;
    import fe_pkg::*;
    typedef RV32I_INSTRUCTION_MNEMONIC_t mnem_t;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        addr_clr = 1'b0;
    logic        err;
    logic [7:0]  err_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] exp_addr = BASE;
    int          exp_errs = 0;

    rv32i_instr_encoder_if #(.ADDR_W(32)) bus ();

    rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .addr_clr (addr_clr),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoder: assembles the word arithmetically from the format rules
    function automatic void ref_encode(input mnem_t m, input logic [31:0] rd, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] u,
                                       output logic [31:0] w, output bit ok);
        byte         fmt;
        logic [31:0] op, f3, f7;
        int          s;
        s = int'(u);
        fmt = "X"; op = 32'h33; f3 = 0; f7 = 0;
        case (m)
            LUI:   begin fmt = "U"; op = 32'h37; end
            AUIPC: begin fmt = "U"; op = 32'h17; end
            JAL:   begin fmt = "J"; op = 32'h6F; end
            JALR:  begin fmt = "I"; op = 32'h67; end
            BEQ:   begin fmt = "B"; op = 32'h63; f3 = 0; end
            BNE:   begin fmt = "B"; op = 32'h63; f3 = 1; end
            BLT:   begin fmt = "B"; op = 32'h63; f3 = 4; end
            BGE:   begin fmt = "B"; op = 32'h63; f3 = 5; end
            BLTU:  begin fmt = "B"; op = 32'h63; f3 = 6; end
            BGEU:  begin fmt = "B"; op = 32'h63; f3 = 7; end
            LB:    begin fmt = "I"; op = 32'h03; f3 = 0; end
            LH:    begin fmt = "I"; op = 32'h03; f3 = 1; end
            LW:    begin fmt = "I"; op = 32'h03; f3 = 2; end
            LBU:   begin fmt = "I"; op = 32'h03; f3 = 4; end
            LHU:   begin fmt = "I"; op = 32'h03; f3 = 5; end
            SB:    begin fmt = "S"; op = 32'h23; f3 = 0; end
            SH:    begin fmt = "S"; op = 32'h23; f3 = 1; end
            SW:    begin fmt = "S"; op = 32'h23; f3 = 2; end
            ADDI:  begin fmt = "I"; op = 32'h13; f3 = 0; end
            SLTI:  begin fmt = "I"; op = 32'h13; f3 = 2; end
            SLTIU: begin fmt = "I"; op = 32'h13; f3 = 3; end
            XORI:  begin fmt = "I"; op = 32'h13; f3 = 4; end
            ORI:   begin fmt = "I"; op = 32'h13; f3 = 6; end
            ANDI:  begin fmt = "I"; op = 32'h13; f3 = 7; end
            SLLI:  begin fmt = "H"; op = 32'h13; f3 = 1; end
            SRLI:  begin fmt = "H"; op = 32'h13; f3 = 5; end
            SRAI:  begin fmt = "H"; op = 32'h13; f3 = 5; f7 = 32; end
            ADD:   begin fmt = "R"; f3 = 0; end
            SUB:   begin fmt = "R"; f3 = 0; f7 = 32; end
            SLL:   begin fmt = "R"; f3 = 1; end
            SLT:   begin fmt = "R"; f3 = 2; end
            SLTU:  begin fmt = "R"; f3 = 3; end
            XOR:   begin fmt = "R"; f3 = 4; end
            SRL:   begin fmt = "R"; f3 = 5; end
            SRA:   begin fmt = "R"; f3 = 5; f7 = 32; end
            OR:    begin fmt = "R"; f3 = 6; end
            AND:   begin fmt = "R"; f3 = 7; end
            ECALL:  fmt = "E";
            EBREAK: fmt = "E";
            default: fmt = "X";
        endcase
        w = 0; ok = 0;
        case (fmt)
            "R": begin ok = 1; w = f7*(1<<25) + rs2*(1<<20) + rs1*(1<<15) + f3*(1<<12) + rd*(1<<7) + op; end
            "I": begin ok = (s >= -2048 && s <= 2047); w = (u & 32'hFFF)*(1<<20) + rs1*(1<<15) + f3*(1<<12) + rd*(1<<7) + op; end
            "H": begin ok = (s >= 0 && s <= 31); w = f7*(1<<25) + (u & 31)*(1<<20) + rs1*(1<<15) + f3*(1<<12) + rd*(1<<7) + op; end
            "S": begin ok = (s >= -2048 && s <= 2047); w = ((u >> 5) & 127)*(1<<25) + rs2*(1<<20) + rs1*(1<<15) + f3*(1<<12) + (u & 31)*(1<<7) + op; end
            "B": begin
                ok = (s >= -4096 && s <= 4094 && s % 2 == 0);
                w = ((u >> 12) & 1)*32'h8000_0000 + ((u >> 5) & 63)*(1<<25) + rs2*(1<<20) + rs1*(1<<15)
                  + f3*(1<<12) + ((u >> 1) & 15)*(1<<8) + ((u >> 11) & 1)*(1<<7) + op;
            end
            "J": begin
                ok = (s >= -(1<<20) && s <= (1<<20) - 2 && s % 2 == 0);
                w = ((u >> 20) & 1)*32'h8000_0000 + ((u >> 1) & 1023)*(1<<21) + ((u >> 11) & 1)*(1<<20)
                  + ((u >> 12) & 255)*(1<<12) + rd*(1<<7) + op;
            end
            "U": begin ok = ((u % 4096) == 0); w = (u & 32'hFFFF_F000) + rd*(1<<7) + op; end
            "E": begin ok = 1; w = (m == EBREAK) ? 32'h0010_0073 : 32'h0000_0073; end
            default: begin ok = 0; w = 0; end
        endcase
    endfunction

    function automatic logic [31:0] pick_imm();
        int bnd [0:18];
        bnd = '{-2049, -2048, 2047, 2048, -1, 0, 31, 32, -4097, -4096, 4094, 4095, 4096,
                -(1<<20), -(1<<20) - 2, (1<<20) - 2, (1<<20), 4096*5, 4096*5 + 1};
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 63)) - 32'd32;
            1: return 32'(bnd[$urandom_range(0, 18)]);
            2: return $urandom;
            3: return ($urandom & 32'hFFFF_F000) | (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0);
            default: return 32'($urandom_range(0, 1<<21)) - 32'(1<<20);
        endcase
    endfunction

    // Drives one request, then collects either the err pulse or the emitted word
    task automatic do_req(input mnem_t m, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input int hold,
                          output bit saw_err, output bit saw_word, output logic [31:0] data,
                          output logic [31:0] addr, output int lat, output int tv, output bit tmo);
        int t0, n;
        saw_err = 0; saw_word = 0; data = 0; addr = 0; lat = 0; tv = 0; tmo = 0;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin tmo = 1; return; end
        bus.in_valid = 1; bus.in_mnem = m; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
        bus.out_ready = (hold == 0);
        t0 = cyc;
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.in_mnem = mnem_t'(6'($urandom)); bus.in_rd = 5'($urandom); bus.in_rs1 = 5'($urandom);
        bus.in_rs2 = 5'($urandom); bus.in_imm = $urandom;
        n = 0;
        while (!err && !bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        if (err) begin
            saw_err = 1; lat = cyc - t0;
            @(posedge clk); #1;
            return;
        end
        if (!bus.out_valid) begin tmo = 1; return; end
        saw_word = 1; lat = cyc - t0; tv = cyc; data = bus.out_data; addr = bus.out_addr;
        repeat (hold) begin @(posedge clk); #1; end
        bus.out_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.in_valid = 0; bus.out_ready = 1; bus.in_mnem = NULL;
        bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'd0)  begin n_bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        n_cmp++; if (bus.out_addr !== BASE)   begin n_bad++; $display("FAIL reset_out_addr got=%h want=%h", bus.out_addr, BASE); end
        n_cmp++; if (err !== 1'b0)            begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
        n_cmp++; if (err_cnt !== 8'd0)        begin n_bad++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        rst_n = 1;
        exp_addr = BASE; exp_errs = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        mnem_t       ms [0:4];
        logic [4:0]  rds [0:4], r1s [0:4], r2s [0:4];
        logic [31:0] ims [0:4], ws [0:4];
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv;
        ms  = '{ADD, ADDI, SW, JAL, SRAI};
        rds = '{5'd1, 5'd5, 5'd7, 5'd1, 5'd1};
        r1s = '{5'd2, 5'd0, 5'd1, 5'd3, 5'd1};
        r2s = '{5'd3, 5'd9, 5'd2, 5'd4, 5'd6};
        ims = '{32'd123, 32'hFFFF_FFFF, 32'd8, 32'd8, 32'd3};
        ws  = '{32'h003100B3, 32'hFFF00293, 32'h0020A423, 32'h008000EF, 32'h4030D093};
        for (int i = 0; i < 5; i++) begin
            do_req(ms[i], rds[i], r1s[i], r2s[i], ims[i], 0, se, sw, d, a, lat, tv, tmo);
            n_cmp++; if (tmo || !sw) begin n_bad++; $display("FAIL directed_%0d_emit timeout=%b word=%b want word", i, tmo, sw); end
            n_cmp++; if (d !== ws[i]) begin n_bad++; $display("FAIL directed_%0d_data got=%h want=%h", i, d, ws[i]); end
            n_cmp++; if (a !== exp_addr) begin n_bad++; $display("FAIL directed_%0d_addr got=%h want=%h", i, a, exp_addr); end
            if (i == 0) begin
                n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL directed_latency got=%0d want=2", lat); end
            end
            exp_addr = exp_addr + 4;
        end
    endtask

    task automatic test_illegal();
        mnem_t       ms [0:2];
        logic [31:0] ims [0:2];
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv;
        ms  = '{BEQ, ADDI, NULL};
        ims = '{32'd3, 32'd2048, 32'd0};
        for (int i = 0; i < 3; i++) begin
            do_req(ms[i], 5'd1, 5'd2, 5'd3, ims[i], 0, se, sw, d, a, lat, tv, tmo);
            exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
            n_cmp++; if (!se || sw || tmo) begin n_bad++; $display("FAIL illegal_%0d got err=%b word=%b timeout=%b want err only", i, se, sw, tmo); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal_%0d_pulse_width got=%b want=0", i, err); end
            n_cmp++; if (err_cnt !== 8'(exp_errs)) begin n_bad++; $display("FAIL illegal_%0d_err_cnt got=%0d want=%0d", i, err_cnt, exp_errs); end
        end
        do_req(ECALL, 5'd31, 5'd17, 5'd9, 32'hDEAD_BEEF, 0, se, sw, d, a, lat, tv, tmo);
        n_cmp++; if (!sw || d !== 32'h0000_0073) begin n_bad++; $display("FAIL ecall got=%h word=%b want=00000073", d, sw); end
        n_cmp++; if (a !== exp_addr) begin n_bad++; $display("FAIL illegal_counter_kept got=%h want=%h", a, exp_addr); end
        exp_addr = exp_addr + 4;
        do_req(EBREAK, 5'd3, 5'd4, 5'd5, 32'h1234_5678, 0, se, sw, d, a, lat, tv, tmo);
        n_cmp++; if (!sw || d !== 32'h0010_0073) begin n_bad++; $display("FAIL ebreak got=%h word=%b want=00100073", d, sw); end
        exp_addr = exp_addr + 4;
    endtask

    task automatic test_back_to_back();
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv, prev;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(ADD, 5'(i), 5'(i + 1), 5'(i + 2), 32'd0, 0, se, sw, d, a, lat, tv, tmo);
            n_cmp++; if (!sw || a !== exp_addr) begin n_bad++; $display("FAIL b2b_%0d_addr got=%h word=%b want=%h", i, a, sw, exp_addr); end
            if (i > 0) begin
                n_cmp++; if (tv - prev !== 3) begin n_bad++; $display("FAIL b2b_%0d_spacing got=%0d want=3", i, tv - prev); end
            end
            prev = tv;
            exp_addr = exp_addr + 4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0; bit ok; int n;
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv;
        ref_encode(SUB, 32'd4, 32'd5, 32'd6, 32'd0, w0, ok);
        bus.in_valid = 1; bus.in_mnem = SUB; bus.in_rd = 4; bus.in_rs1 = 5; bus.in_rs2 = 6; bus.in_imm = 0;
        bus.out_ready = 0;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.in_rd = 5'($urandom);
        n = 0;
        while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        n_cmp++; if (!bus.out_valid) begin n_bad++; $display("FAIL bp_reach_emit got out_valid=0 want 1"); end
        for (int i = 0; i < 10; i++) begin
            if (i == 5) addr_clr = 1;
            @(posedge clk); #1;
            addr_clr = 0;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== w0 || bus.out_addr !== exp_addr) begin
                n_bad++;
                $display("FAIL bp_hold_%0d got v=%b rdy=%b d=%h a=%h want v=1 rdy=0 d=%h a=%h",
                         i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_addr, w0, exp_addr);
            end
        end
        bus.out_ready = 1; addr_clr = 1;
        @(posedge clk); #1;
        addr_clr = 0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got out_valid=%b want 0", bus.out_valid); end
        exp_addr = BASE;
        do_req(OR, 5'd8, 5'd9, 5'd10, 32'd0, 0, se, sw, d, a, lat, tv, tmo);
        n_cmp++; if (!sw || a !== BASE) begin n_bad++; $display("FAIL bp_clr_addr got=%h word=%b want=%h", a, sw, BASE); end
        exp_addr = exp_addr + 4;
    endtask

    task automatic test_random();
        mnem_t m; logic [4:0] rd, rs1, rs2; logic [31:0] imm, ew; bit ok;
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv, hold;
        for (int i = 0; i < 200; i++) begin
            m = mnem_t'(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) != 0) m = mnem_t'(6'($urandom_range(1, 39)));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            imm = pick_imm();
            hold = $urandom_range(0, 3);
            ref_encode(m, 32'(rd), 32'(rs1), 32'(rs2), imm, ew, ok);
            do_req(m, rd, rs1, rs2, imm, hold, se, sw, d, a, lat, tv, tmo);
            n_cmp++;
            if (tmo || se !== !ok || sw !== ok) begin
                n_bad++;
                $display("FAIL rand_%0d_legal mnem=%0d imm=%h got err=%b word=%b timeout=%b want legal=%b", i, m, imm, se, sw, tmo, ok);
            end else if (ok) begin
                n_cmp++; if (d !== ew) begin n_bad++; $display("FAIL rand_%0d_data mnem=%0d imm=%h got=%h want=%h", i, m, imm, d, ew); end
                n_cmp++; if (a !== exp_addr) begin n_bad++; $display("FAIL rand_%0d_addr got=%h want=%h", i, a, exp_addr); end
            end
            if (ok) exp_addr = exp_addr + 4;
            else    exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
            if (!ok) begin
                n_cmp++; if (err_cnt !== 8'(exp_errs)) begin n_bad++; $display("FAIL rand_%0d_err_cnt got=%0d want=%0d", i, err_cnt, exp_errs); end
            end
        end
    endtask

    task automatic test_err_saturation();
        bit se, sw, tmo; logic [31:0] d, a; int lat, tv, misses;
        misses = 0;
        for (int i = 0; i < 260; i++) begin
            do_req(NULL, 5'd0, 5'd0, 5'd0, 32'd0, 0, se, sw, d, a, lat, tv, tmo);
            if (!se) misses++;
            exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
        end
        n_cmp++; if (misses != 0) begin n_bad++; $display("FAIL sat_err_pulses got %0d missing want 0", misses); end
        n_cmp++; if (err_cnt !== 8'(exp_errs)) begin n_bad++; $display("FAIL sat_err_cnt got=%0d want=%0d", err_cnt, exp_errs); end
    endtask

    task automatic test_reset_mid_emit();
        bit se, sw, tmo, leak; logic [31:0] d, a, ew; bit ok; int lat, tv, n;
        bus.in_valid = 1; bus.in_mnem = XOR; bus.in_rd = 1; bus.in_rs1 = 1; bus.in_rs2 = 1; bus.in_imm = 0;
        bus.out_ready = 0;
        @(posedge clk); #1;
        bus.in_valid = 0;
        n = 0;
        while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        n_cmp++; if (!bus.out_valid) begin n_bad++; $display("FAIL rst_emit_reach got out_valid=0 want 1"); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_emit_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_emit_err_cnt got=%0d want=0", err_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_emit_in_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
        rst_n = 1;
        exp_addr = BASE; exp_errs = 0;
        bus.out_ready = 1;
        leak = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.out_valid) leak = 1; end
        n_cmp++; if (leak) begin n_bad++; $display("FAIL rst_emit_no_leak got out_valid=1 want 0"); end
        ref_encode(SLT, 32'd2, 32'd3, 32'd4, 32'd0, ew, ok);
        do_req(SLT, 5'd2, 5'd3, 5'd4, 32'd0, 0, se, sw, d, a, lat, tv, tmo);
        n_cmp++; if (!sw || a !== BASE || d !== ew) begin n_bad++; $display("FAIL rst_emit_next got d=%h a=%h want d=%h a=%h", d, a, ew, BASE); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_err_saturation();
        test_reset_mid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
